// File: rtl/wb_snoop_gen.sv
// Wishbone write-snoop generator for the main-RAM slave port.
// Emits registered, line-coalesced cache snoops plus saturating debug counters.
module wb_snoop_gen #(
  parameter int AW         = 32,
  parameter int LINE_WIDTH = 5,
  parameter bit COALESCE   = 1'b1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic [AW-1:0]        wb_adr_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic [2:0]           wb_cti_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  input  logic                 cnt_clr_i,
  output logic [AW-1:0]        snoop_adr_o,
  output logic                 snoop_en_o,
  output logic [CNT_WIDTH-1:0] snoop_cnt_o,
  output logic [CNT_WIDTH-1:0] supp_cnt_o
);

  localparam int TW = AW - LINE_WIDTH;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]           state_q;
  logic [0:0]           state_d;
  logic                 line_vld_q;
  logic                 line_vld_d;
  logic [TW-1:0]        tag_q;
  logic [TW-1:0]        tag_d;
  logic [TW-1:0]        tag;
  logic                 wbeat;
  logic                 rd_req;
  logic                 cti_burst;
  logic                 cti_eob;
  logic                 emit;
  logic                 supp;
  logic [AW-1:0]        adr_q;
  logic                 en_q;
  logic [CNT_WIDTH-1:0] snoop_cnt_q;
  logic [CNT_WIDTH-1:0] supp_cnt_q;

  assign tag       = wb_adr_i[AW-1:LINE_WIDTH];
  assign wbeat     = wb_cyc_i & wb_stb_i & wb_we_i & wb_ack_i & ~wb_err_i;
  assign rd_req    = wb_cyc_i & wb_stb_i & ~wb_we_i;
  assign cti_burst = (wb_cti_i == 3'b001) | (wb_cti_i == 3'b010);
  assign cti_eob   = (wb_cti_i == 3'b111);

  always_comb begin
    state_d    = state_q;
    line_vld_d = line_vld_q;
    tag_d      = tag_q;
    emit       = 1'b0;
    supp       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wbeat) begin
          emit = 1'b1;
          if (cti_burst) begin
            state_d    = S_BURST;
            tag_d      = tag;
            line_vld_d = 1'b1;
          end
        end
      end
      S_BURST: begin
        if (wbeat) begin
          if (COALESCE && line_vld_q && (tag == tag_q)) begin
            supp = 1'b1;
          end else begin
            emit  = 1'b1;
            tag_d = tag;
          end
          if (cti_eob) begin
            state_d    = S_IDLE;
            line_vld_d = 1'b0;
          end
        end else if (!wb_cyc_i || rd_req) begin
          // bus dropped or turned into a read: abandon the burst silently
          state_d    = S_IDLE;
          line_vld_d = 1'b0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        line_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= S_IDLE;
      line_vld_q <= 1'b0;
      tag_q      <= '0;
      adr_q      <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_vld_q <= line_vld_d;
      tag_q      <= tag_d;
      en_q       <= emit;
      if (emit)
        adr_q <= {wb_adr_i[AW-1:2], 2'b00};
    end
  end

  // clear wins over a same-cycle increment; the snoop itself still goes out
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      snoop_cnt_q <= '0;
      supp_cnt_q  <= '0;
    end else if (cnt_clr_i) begin
      snoop_cnt_q <= '0;
      supp_cnt_q  <= '0;
    end else begin
      if (emit && !(&snoop_cnt_q))
        snoop_cnt_q <= snoop_cnt_q + 1'b1;
      if (supp && !(&supp_cnt_q))
        supp_cnt_q <= supp_cnt_q + 1'b1;
    end
  end

  assign snoop_adr_o = adr_q;
  assign snoop_en_o  = en_q;
  assign snoop_cnt_o = snoop_cnt_q;
  assign supp_cnt_o  = supp_cnt_q;

endmodule

// File: tb/tb_wb_snoop_gen.sv
// Directed bench for wb_snoop_gen: coalescing, non-coalescing and
// 4-bit-counter variants share one bus.
module tb_wb_snoop_gen;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic        ack;
  logic        err;
  logic        clr;

  logic [31:0] a1, a0, a4;
  logic        e1, e0, e4;
  logic [15:0] sc1, sp1, sc0, sp0;
  logic [3:0]  sc4, sp4;

  int errs;
  int checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_snoop_gen #(.COALESCE(1'b1)) u_c1 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_we_i(we),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_ack_i(ack),
    .wb_err_i(err), .cnt_clr_i(clr), .snoop_adr_o(a1), .snoop_en_o(e1),
    .snoop_cnt_o(sc1), .supp_cnt_o(sp1)
  );

  wb_snoop_gen #(.COALESCE(1'b0)) u_c0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_we_i(we),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_ack_i(ack),
    .wb_err_i(err), .cnt_clr_i(clr), .snoop_adr_o(a0), .snoop_en_o(e0),
    .snoop_cnt_o(sc0), .supp_cnt_o(sp0)
  );

  wb_snoop_gen #(.CNT_WIDTH(4)) u_w4 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_we_i(we),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_ack_i(ack),
    .wb_err_i(err), .cnt_clr_i(clr), .snoop_adr_o(a4), .snoop_en_o(e4),
    .snoop_cnt_o(sc4), .supp_cnt_o(sp4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; ack = 1'b0;
    err = 1'b0; cti = 3'b000; adr = '0;
  endtask

  task automatic beat(input logic [31:0] a, input logic w,
                      input logic [2:0] c);
    cyc = 1'b1; stb = 1'b1; we = w; ack = 1'b1;
    err = 1'b0; cti = c; adr = a;
  endtask

  initial begin
    errs = 0;
    checks = 0;
    clr = 1'b0;
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_en", 32'(e1), 32'd0);
    chk("rst_adr", a1, 32'h0);
    chk("rst_scnt", 32'(sc1), 32'd0);
    chk("rst_supp", 32'(sp1), 32'd0);

    // single classic write
    beat(32'h0000_1236, 1'b1, 3'b000);
    tick();
    idle();
    chk("sw_en", 32'(e1), 32'd1);
    chk("sw_adr", a1, 32'h0000_1234);
    chk("sw_scnt", 32'(sc1), 32'd1);
    tick();
    chk("sw_en_drop", 32'(e1), 32'd0);
    chk("sw_adr_hold", a1, 32'h0000_1234);

    // error-terminated write and strobe without ack
    cyc = 1'b1; stb = 1'b1; we = 1'b1; err = 1'b1; adr = 32'h40;
    tick();
    err = 1'b0;
    tick();
    idle();
    chk("err_no_en", 32'(e1), 32'd0);
    chk("noack_no_en", 32'(e0), 32'd0);
    chk("err_scnt", 32'(sc1), 32'd1);

    // 8-beat read burst
    for (int i = 0; i < 8; i++) begin
      beat(32'h100 + 32'(4 * i), 1'b0, (i == 7) ? 3'b111 : 3'b010);
      tick();
      chk("rd_en", 32'(e1), 32'd0);
    end
    idle();
    tick();
    chk("rd_scnt", 32'(sc1), 32'd1);
    chk("rd_supp", 32'(sp1), 32'd0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_scnt", 32'(sc1), 32'd0);

    // 8-beat write burst, coalescing vs. not
    for (int i = 0; i < 8; i++) begin
      beat(32'h200 + 32'(4 * i), 1'b1, (i == 7) ? 3'b111 : 3'b010);
      tick();
      chk("b8_c1_en", 32'(e1), (i == 0) ? 32'd1 : 32'd0);
      chk("b8_c1_adr", a1, 32'h200);
      chk("b8_c0_en", 32'(e0), 32'd1);
      chk("b8_c0_adr", a0, 32'h200 + 32'(4 * i));
    end
    idle();
    tick();
    chk("b8_c1_en_end", 32'(e1), 32'd0);
    chk("b8_c1_scnt", 32'(sc1), 32'd1);
    chk("b8_c1_supp", 32'(sp1), 32'd7);
    chk("b8_c0_scnt", 32'(sc0), 32'd8);
    chk("b8_c0_supp", 32'(sp0), 32'd0);

    // back in IDLE: same-line classic write must emit
    beat(32'h204, 1'b1, 3'b000);
    tick();
    idle();
    chk("post_idle_en", 32'(e1), 32'd1);
    chk("post_idle_adr", a1, 32'h204);
    chk("post_idle_scnt", 32'(sc1), 32'd2);
    tick();

    // 4-beat burst crossing a line, clear on the first beat
    beat(32'h218, 1'b1, 3'b010);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("b4_en0", 32'(e1), 32'd1);
    chk("b4_adr0", a1, 32'h218);
    chk("b4_clr_scnt", 32'(sc1), 32'd0);
    chk("b4_clr_supp", 32'(sp1), 32'd0);
    beat(32'h21C, 1'b1, 3'b010);
    tick();
    chk("b4_en1", 32'(e1), 32'd0);
    beat(32'h220, 1'b1, 3'b010);
    tick();
    chk("b4_en2", 32'(e1), 32'd1);
    chk("b4_adr2", a1, 32'h220);
    beat(32'h224, 1'b1, 3'b111);
    tick();
    idle();
    chk("b4_en3", 32'(e1), 32'd0);
    chk("b4_scnt", 32'(sc1), 32'd1);
    chk("b4_supp", 32'(sp1), 32'd2);
    tick();

    // reset asserted on the third beat of a burst
    beat(32'h300, 1'b1, 3'b010);
    tick();
    chk("rb_en0", 32'(e1), 32'd1);
    beat(32'h304, 1'b1, 3'b010);
    tick();
    beat(32'h308, 1'b1, 3'b010);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    chk("rb_en", 32'(e1), 32'd0);
    chk("rb_adr", a1, 32'h0);
    chk("rb_scnt", 32'(sc1), 32'd0);
    chk("rb_supp", 32'(sp1), 32'd0);
    chk("rb_c0_en", 32'(e0), 32'd0);
    tick();

    // same line again after reset
    beat(32'h300, 1'b1, 3'b010);
    tick();
    chk("ra_en0", 32'(e1), 32'd1);
    chk("ra_adr0", a1, 32'h300);
    beat(32'h304, 1'b1, 3'b010);
    tick();
    chk("ra_en1", 32'(e1), 32'd0);
    beat(32'h308, 1'b1, 3'b111);
    tick();
    idle();
    chk("ra_en2", 32'(e1), 32'd0);
    chk("ra_scnt", 32'(sc1), 32'd1);
    chk("ra_supp", 32'(sp1), 32'd2);
    tick();

    // 20 back-to-back single writes saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      beat(32'h400 + 32'(4 * i), 1'b1, 3'b000);
      tick();
      chk("bb_en", 32'(e1), 32'd1);
    end
    idle();
    tick();
    chk("sat_w4", 32'(sc4), 32'd15);
    chk("sat_w4_supp", 32'(sp4), 32'd2);
    chk("sat_c1", 32'(sc1), 32'd21);
    chk("sat_adr", a4, 32'h44C);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_w4", 32'(sc4), 32'd0);
    chk("clr_w4_supp", 32'(sp4), 32'd0);
    chk("clr_c1", 32'(sc1), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/wb_snoop_gen.md
Name: wb_snoop_gen

Overview:
- Passive monitor on the main-RAM Wishbone slave port.
- Turns completed write beats into the snoop address/enable pair that is broadcast to every mor1kx core's data-cache snoop inputs.
- Registers the snoop output and can coalesce burst beats that fall in the same cache line, so each line invalidates once per burst.
- Keeps saturating event counters for debug and verification.

Parameters:
- AW, 32: address width.
- LINE_WIDTH, 5: log2 of cache-line bytes. Must match OPTION_DCACHE_BLOCK_WIDTH.
- COALESCE, 1: 1 = suppress repeat snoops to the same line within one burst; 0 = one snoop per acked write beat.
- CNT_WIDTH, 16: counter width.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_n_i  in  1  synchronous reset, active low
- wb_adr_i  in  AW  slave-port address (monitored)
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle
- wb_stb_i  in  1  strobe
- wb_cti_i  in  3  cycle type
- wb_ack_i  in  1  slave ack (monitored)
- wb_err_i  in  1  slave error (monitored)
- cnt_clr_i  in  1  synchronous counter clear
- snoop_adr_o  out  AW  snooped write address, word aligned
- snoop_en_o  out  1  single-cycle snoop strobe
- snoop_cnt_o  out  CNT_WIDTH  emitted snoops, saturating
- supp_cnt_o  out  CNT_WIDTH  coalesced (suppressed) beats, saturating

Behaviour:
- One clock; reset is synchronous and active-low. Sampled on the rising edge of wb_clk_i while wb_rst_n_i==0.
- Reset values: snoop_adr_o=0, snoop_en_o=0, snoop_cnt_o=0, supp_cnt_o=0, FSM=IDLE, line_vld=0.
- Write beat: wb_cyc_i & wb_stb_i & wb_we_i & wb_ack_i. Nothing else creates a snoop.
- Ignored: reads, err-terminated beats (wb_err_i without ack), and stb without ack.
- Line tag: wb_adr_i[AW-1:LINE_WIDTH].
- Emitted beat: snoop_en_o=1 exactly one cycle after the ack cycle. snoop_adr_o = {wb_adr_i[AW-1:2],2'b00} of that beat, held until the next emission.
- Throughput: back-to-back beats produce back-to-back snoops. No buffering is needed because there is at most one ack per cycle.
- FSM states:
  - IDLE, on a write beat:
    - cti 000 or 111 (classic / end-of-burst): emit, stay IDLE.
    - cti 001 or 010 (burst): emit, latch tag, line_vld=1, go to BURST.
  - BURST, on a write beat:
    - COALESCE=1 and tag == latched tag: suppress, supp_cnt_o+1.
    - Otherwise: emit and re-latch the tag. This covers a linear burst crossing into the next line.
    - Beat cti==111: go to IDLE, line_vld=0 (suppression still applies to that beat).
  - BURST exit without ack: wb_cyc_i==0, or wb_cyc_i & wb_stb_i & !wb_we_i → IDLE, line_vld=0, no emission.
- COALESCE=0: FSM still runs; every write beat emits; supp_cnt_o stays 0.
- Counters:
  - Increment by 1 per event and saturate at all-ones.
  - cnt_clr_i=1 zeroes both counters. A clear takes priority over a same-cycle increment, but the snoop itself is still emitted.
- Reset mid-burst: FSM→IDLE; a pending registered snoop is dropped (snoop_en_o=0 next cycle).
- Outputs are driven only from registers; no combinational path from inputs to outputs.

Test Plan:
- Single write: adr=0x0000_1236, cti=000, ack at cycle N → snoop_en_o=1 at N+1 only, snoop_adr_o=0x0000_1234; snoop_cnt_o=1.
- Read burst of 8 beats at 0x100 → snoop_en_o never asserts; both counters stay 0.
- COALESCE=1, 8-beat incrementing write burst 0x200..0x21C (cti 010 ×7, then 111), one ack/cycle:
  - one snoop at 0x200, one cycle after the first ack;
  - snoop_cnt_o=1, supp_cnt_o=7; FSM back in IDLE.
- COALESCE=1, 4-beat incrementing burst 0x218..0x224 → snoops at 0x218 and 0x220; supp_cnt_o=2.
- COALESCE=0, same 8-beat burst as above → 8 consecutive snoop_en_o pulses, addresses 0x200..0x21C; supp_cnt_o=0.
- Reset and saturation:
  - Assert wb_rst_n_i=0 during beat 3 of a burst → all outputs 0 next cycle.
  - A following burst to the same line emits again.
  - With CNT_WIDTH=4, 20 single writes → snoop_cnt_o=15.
  - cnt_clr_i pulse → snoop_cnt_o=0.
